ofs_fim_pcie_ss_rx_hdr_split: RTL and testbench

- Sits directly downstream of the RX segment aligner. Consumes its single-packet stream: at most one SOP per beat, always at byte 0, nothing valid beyond EOP.
- Strips the in-band PCIe SS header from the low bytes of each SOP beat and presents it as a side-band header.
- Re-packs the payload so it starts at byte 0 of the data bus, carrying the residue across beats.

---
 rtl/ofs_fim_pcie_ss_rx_hdr_split.sv | 182 ++++++++++++++++++
 tb/tb_ofs_fim_pcie_ss_rx_hdr_split.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_fim_pcie_ss_rx_hdr_split.sv
// ofs_fim_pcie_ss_rx_hdr_split
// Strips the in-band PCIe SS header from the low half of each SOP beat,
// presents it side-band, and re-packs the payload to start at byte 0.
// Optional statistics counters: define OFS_FIM_RX_HDR_SPLIT_STATS_EN.
module ofs_fim_pcie_ss_rx_hdr_split #(
   parameter int unsigned TDATA_WIDTH = 512,
   parameter int unsigned HDR_WIDTH   = 256
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_tvalid,
   output logic                       in_tready,
   input  logic [TDATA_WIDTH-1:0]     in_tdata,
   input  logic [TDATA_WIDTH/8-1:0]   in_tkeep,
   input  logic                       in_tlast,
   input  logic                       in_sop,
   output logic                       out_tvalid,
   input  logic                       out_tready,
   output logic                       out_hdr_valid,
   output logic [HDR_WIDTH-1:0]       out_hdr,
   output logic [TDATA_WIDTH-1:0]     out_tdata,
   output logic [TDATA_WIDTH/8-1:0]   out_tkeep,
   output logic                       out_tlast,
   output logic [31:0]                stat_pkts,
   output logic [31:0]                stat_flush
);

   localparam int unsigned KEEP_W  = TDATA_WIDTH / 8;
   localparam int unsigned HKEEP_W = HDR_WIDTH / 8;

   typedef enum logic [1:0] {S_IDLE, S_CARRY, S_FLUSH} state_t;

   state_t                 r_state;
   logic [HDR_WIDTH-1:0]   r_carry;
   logic [HKEEP_W-1:0]     r_carry_keep;
   logic                   r_hdr_pending;

   logic                   r_out_tvalid;
   logic                   r_out_hdr_valid;
   logic [HDR_WIDTH-1:0]   r_out_hdr;
   logic [TDATA_WIDTH-1:0] r_out_tdata;
   logic [KEEP_W-1:0]      r_out_tkeep;
   logic                   r_out_tlast;

   logic                   w_ld;
   logic                   w_acc;
   logic [HDR_WIDTH-1:0]   w_lo;
   logic [HDR_WIDTH-1:0]   w_hi;
   logic [HKEEP_W-1:0]     w_lo_keep;
   logic [HKEEP_W-1:0]     w_hi_keep;

   assign w_lo      = in_tdata[HDR_WIDTH-1:0];
   assign w_hi      = in_tdata[TDATA_WIDTH-1:HDR_WIDTH];
   assign w_lo_keep = in_tkeep[HKEEP_W-1:0];
   assign w_hi_keep = in_tkeep[KEEP_W-1:HKEEP_W];

   // Output register may load when empty or being drained this cycle
   assign w_ld      = !r_out_tvalid || out_tready;
   assign in_tready = w_ld && (r_state != S_FLUSH);
   assign w_acc     = in_tvalid && in_tready;

   assign out_tvalid    = r_out_tvalid;
   assign out_hdr_valid = r_out_hdr_valid;
   assign out_hdr       = r_out_hdr;
   assign out_tdata     = r_out_tdata;
   assign out_tkeep     = r_out_tkeep;
   assign out_tlast     = r_out_tlast;

   // Header split / re-pack FSM with the registered output stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_carry         <= '0;
         r_carry_keep    <= '0;
         r_hdr_pending   <= 1'b0;
         r_out_tvalid    <= 1'b0;
         r_out_hdr_valid <= 1'b0;
         r_out_hdr       <= '0;
         r_out_tdata     <= '0;
         r_out_tkeep     <= '0;
         r_out_tlast     <= 1'b0;
      end else begin
         if (w_ld) begin
            r_out_tvalid    <= 1'b0;
            r_out_hdr_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               // Non-SOP beats here are dropped
               if (w_acc && in_sop) begin
                  r_out_hdr <= w_lo;
                  if (in_tlast) begin
                     r_out_tvalid    <= 1'b1;
                     r_out_hdr_valid <= 1'b1;
                     r_out_tdata     <= {{HDR_WIDTH{1'b0}}, w_hi};
                     r_out_tkeep     <= {{HKEEP_W{1'b0}}, w_hi_keep};
                     r_out_tlast     <= 1'b1;
                  end else begin
                     r_carry       <= w_hi;
                     r_carry_keep  <= w_hi_keep;
                     r_hdr_pending <= 1'b1;
                     r_state       <= S_CARRY;
                  end
               end
            end
            S_CARRY: begin
               if (w_acc) begin
                  r_out_tvalid    <= 1'b1;
                  r_out_hdr_valid <= r_hdr_pending;
                  r_out_tdata     <= {w_lo, r_carry};
                  r_out_tkeep     <= {w_lo_keep, r_carry_keep};
                  r_hdr_pending   <= 1'b0;
                  r_carry         <= w_hi;
                  r_carry_keep    <= w_hi_keep;
                  r_out_tlast     <= 1'b0;
                  if (in_tlast) begin
                     if (w_hi_keep == '0) begin
                        r_out_tlast <= 1'b1;
                        r_state     <= S_IDLE;
                     end else begin
                        r_state     <= S_FLUSH;
                     end
                  end
               end
            end
            S_FLUSH: begin
               // Residue of the last input beat goes out on its own beat
               if (w_ld) begin
                  r_out_tvalid    <= 1'b1;
                  r_out_hdr_valid <= 1'b0;
                  r_out_tdata     <= {{HDR_WIDTH{1'b0}}, r_carry};
                  r_out_tkeep     <= {{HKEEP_W{1'b0}}, r_carry_keep};
                  r_out_tlast     <= 1'b1;
                  r_carry_keep    <= '0;
                  r_state         <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef OFS_FIM_RX_HDR_SPLIT_STATS_EN
   logic        r_out_is_flush;
   logic [31:0] r_stat_pkts;
   logic [31:0] r_stat_flush;

   // Remember whether the beat in the output register came from FLUSH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_is_flush <= 1'b0;
      end else if (w_ld) begin
         r_out_is_flush <= (r_state == S_FLUSH);
      end
   end

   // Count packets and flush beats on downstream acceptance (wrapping)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_pkts  <= '0;
         r_stat_flush <= '0;
      end else if (r_out_tvalid && out_tready) begin
         if (r_out_tlast)    r_stat_pkts  <= r_stat_pkts + 32'd1;
         if (r_out_is_flush) r_stat_flush <= r_stat_flush + 32'd1;
      end
   end

   assign stat_pkts  = r_stat_pkts;
   assign stat_flush = r_stat_flush;
`else
   assign stat_pkts  = '0;
   assign stat_flush = '0;
`endif

`ifndef SYNTHESIS
   // A second SOP inside a packet is a protocol error upstream
   a_sop_in_carry: assert property (@(posedge clk) disable iff (rst)
      !((r_state == S_CARRY) && w_acc && in_sop))
      else $error("rx_hdr_split: SOP received mid-packet");
`endif

endmodule

// File: tb/tb_ofs_fim_pcie_ss_rx_hdr_split.sv
// Scoreboard bench for ofs_fim_pcie_ss_rx_hdr_split.
module tb_ofs_fim_pcie_ss_rx_hdr_split;

   localparam int unsigned TW = 512;
   localparam int unsigned HW = 256;
   localparam int unsigned KW = TW / 8;

   typedef struct packed {
      logic          hv;
      logic [HW-1:0] hdr;
      logic [TW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_tvalid;
   logic          in_tready;
   logic [TW-1:0] in_tdata;
   logic [KW-1:0] in_tkeep;
   logic          in_tlast;
   logic          in_sop;
   logic          out_tvalid;
   logic          out_tready = 1'b1;
   logic          out_hdr_valid;
   logic [HW-1:0] out_hdr;
   logic [TW-1:0] out_tdata;
   logic [KW-1:0] out_tkeep;
   logic          out_tlast;
   logic [31:0]   stat_pkts;
   logic [31:0]   stat_flush;

   int    checks = 0;
   int    errors = 0;
   int    rx_cnt = 0;
   int    tready_mode = 0;   // 0: always ready, 1: toggle, 2: hold low
   beat_t exp_q[$];
   beat_t held;
   logic  stall_prev = 1'b0;

   ofs_fim_pcie_ss_rx_hdr_split #(.TDATA_WIDTH(TW), .HDR_WIDTH(HW)) dut (
      .clk(clk), .rst(rst),
      .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
      .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_sop(in_sop),
      .out_tvalid(out_tvalid), .out_tready(out_tready),
      .out_hdr_valid(out_hdr_valid), .out_hdr(out_hdr),
      .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
      .stat_pkts(stat_pkts), .stat_flush(stat_flush)
   );

   always #5 clk = ~clk;

   // Downstream ready pattern
   always @(posedge clk) begin
      #1;
      case (tready_mode)
         1:       out_tready = ~out_tready;
         2:       out_tready = 1'b0;
         default: out_tready = 1'b1;
      endcase
   end

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] ev);
      checks++;
      if (act !== ev) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, ev);
      end
   endtask

   // Monitor: pops expected beats on handshake, checks hold during stalls
   always @(negedge clk) begin
      beat_t cur;
      beat_t ev;
      cur = '{hv: out_hdr_valid, hdr: out_hdr, data: out_tdata, keep: out_tkeep, last: out_tlast};
      if (rst) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (!out_tvalid || cur !== held) begin
               errors++;
               $display("FAIL stall_hold valid=%0b keep=%h/%h last=%0b/%0b", out_tvalid,
                        cur.keep, held.keep, cur.last, held.last);
            end
         end
         if (out_tvalid && out_tready) begin
            rx_cnt++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat keep=%h last=%0b", out_tkeep, out_tlast);
            end else begin
               ev = exp_q.pop_front();
               chk("hdr_valid", TW'(out_hdr_valid), TW'(ev.hv));
               if (ev.hv) chk("hdr", TW'(out_hdr), TW'(ev.hdr));
               chk("tdata", out_tdata, ev.data);
               chk("tkeep", TW'(out_tkeep), TW'(ev.keep));
               chk("tlast", TW'(out_tlast), TW'(ev.last));
            end
         end
         stall_prev = out_tvalid && !out_tready;
         held       = cur;
      end
   end

   task automatic send(input logic [TW-1:0] d, input logic [KW-1:0] k, input logic l, input logic s);
      int n;
      n = 0;
      in_tvalid = 1'b1; in_tdata = d; in_tkeep = k; in_tlast = l; in_sop = s;
      @(negedge clk);
      while (!in_tready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("send_timeout", TW'(1), TW'(0));
      @(posedge clk);
      #1;
      in_tvalid = 1'b0;
   endtask

   task automatic push(input logic hv, input logic [HW-1:0] h, input logic [TW-1:0] d,
                       input logic [KW-1:0] k, input logic l);
      beat_t b;
      b = '{hv: hv, hdr: h, data: d, keep: k, last: l};
      exp_q.push_back(b);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_tvalid) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain_timeout", TW'(n >= 2000), TW'(0));
   endtask

   function automatic logic [HW-1:0] pat(input logic [31:0] w);
      return {8{w}};
   endfunction

   localparam logic [KW-1:0] K_ALL = '1;
   localparam logic [KW-1:0] K_LO  = {32'h0, 32'hFFFF_FFFF};

   initial begin
      logic [HW-1:0] h, p0, p1, p2, p3, p4;
      int base;
      rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0; in_sop = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", TW'(out_tvalid), TW'(0));
      chk("rst_tdata", out_tdata, TW'(0));
      chk("rst_hdr", TW'(out_hdr), TW'(0));
      chk("rst_stats", TW'({stat_pkts, stat_flush}), TW'(0));
      rst = 1'b0;

      // Header-only packet
      h = pat(32'hA5A5_A5A5);
      push(1'b1, h, TW'(0), '0, 1'b1);
      send({{HW{1'b0}}, h}, K_LO, 1'b1, 1'b1);
      chk("hdr_only_latency", TW'(out_tvalid), TW'(1));
      wait_drain();

      // 32 B header + 128 B payload: two full output beats
      h = pat(32'h1111_0000); p0 = pat(32'h2222_0000); p1 = pat(32'h3333_0000);
      p2 = pat(32'h4444_0000); p3 = pat(32'h5555_0000);
      push(1'b1, h, {p1, p0}, K_ALL, 1'b0);
      push(1'b0, '0, {p3, p2}, K_ALL, 1'b1);
      send({p0, h}, K_ALL, 1'b0, 1'b1);
      send({p2, p1}, K_ALL, 1'b0, 1'b0);
      send({{HW{1'b0}}, p3}, K_LO, 1'b1, 1'b0);
      wait_drain();

      // 32 B header + 144 B payload: ends with a 16 B flush beat
      h = pat(32'h6666_0001); p0 = pat(32'h7777_0001); p1 = pat(32'h8888_0001);
      p2 = pat(32'h9999_0001); p3 = pat(32'hAAAA_0001); p4 = {128'h0, 128'hBBBB_CCCC_DDDD_EEEE_0123_4567_89AB_CDEF};
      push(1'b1, h, {p1, p0}, K_ALL, 1'b0);
      push(1'b0, '0, {p3, p2}, K_ALL, 1'b0);
      push(1'b0, '0, {{HW{1'b0}}, p4}, {48'h0, 16'hFFFF}, 1'b1);
      send({p0, h}, K_ALL, 1'b0, 1'b1);
      send({p2, p1}, K_ALL, 1'b0, 1'b0);
      send({p4, p3}, {16'h0, 48'hFFFF_FFFF_FFFF}, 1'b1, 1'b0);
      chk("flush_tready", TW'(in_tready), TW'(0));
      wait_drain();
`ifdef OFS_FIM_RX_HDR_SPLIT_STATS_EN
      chk("stat_flush", TW'(stat_flush), TW'(1));
      chk("stat_pkts3", TW'(stat_pkts), TW'(3));
`else
      chk("stat_flush_off", TW'(stat_flush), TW'(0));
`endif

      // Async reset mid-packet with an output beat stalled
      tready_mode = 2;
      @(posedge clk);
      #2;
      send({pat(32'hDEAD_0000), pat(32'hBEEF_0000)}, K_ALL, 1'b0, 1'b1);
      send({pat(32'hDEAD_0002), pat(32'hDEAD_0001)}, K_ALL, 1'b0, 1'b0);
      chk("pre_rst_tvalid", TW'(out_tvalid), TW'(1));
      #3;
      rst = 1'b1;
      #1;
      chk("arst_tvalid", TW'(out_tvalid), TW'(0));
      chk("arst_tdata", out_tdata, TW'(0));
      chk("arst_tkeep", TW'(out_tkeep), TW'(0));
      chk("arst_hdr", TW'({out_hdr_valid, out_tlast, out_hdr}), TW'(0));
      tready_mode = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #2;
      h = pat(32'hC0DE_0000); p0 = pat(32'hF00D_0000);
      push(1'b1, h, {{HW{1'b0}}, p0}, K_LO, 1'b1);
      send({p0, h}, K_ALL, 1'b1, 1'b1);
      wait_drain();

      // Non-SOP beat in IDLE is dropped
      in_tvalid = 1'b1; in_tdata = {pat(32'h0BAD_0BAD), pat(32'h0BAD_0BAD)};
      in_tkeep = K_ALL; in_tlast = 1'b1; in_sop = 1'b0;
      @(negedge clk);
      chk("drop_tready", TW'(in_tready), TW'(1));
      @(posedge clk);
      #1;
      in_tvalid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("drop_no_out", TW'(out_tvalid), TW'(0));
      end

      // 100 back-to-back single-beat packets with toggling ready
      @(posedge clk);
      #3;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      tready_mode = 1;
      base = rx_cnt;
      for (int i = 0; i < 100; i++) begin
         h  = pat(32'hA000_0000 + 32'(i));
         p0 = pat(32'h5000_0000 + 32'(i));
         push(1'b1, h, {{HW{1'b0}}, p0}, K_LO, 1'b1);
      end
      for (int i = 0; i < 100; i++) begin
         send({pat(32'h5000_0000 + 32'(i)), pat(32'hA000_0000 + 32'(i))}, K_ALL, 1'b1, 1'b1);
      end
      wait_drain();
      tready_mode = 0;
      chk("b2b_count", TW'(rx_cnt - base), TW'(100));
`ifdef OFS_FIM_RX_HDR_SPLIT_STATS_EN
      chk("stat_pkts100", TW'(stat_pkts), TW'(100));
`else
      chk("stat_pkts_off", TW'(stat_pkts), TW'(0));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
